// File: rtl/axi_trace_capture.sv
// Passive AXI address-channel tracer: every AW/AR handshake becomes a timestamped
// record with its valid-to-ready wait count, buffered in a dual-write FIFO.

package axi_trace_capture_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        ax_chan_t ar;
        logic     ar_valid;
    } axi_req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
    } axi_resp_t;
endpackage

module axi_trace_capture #(
    parameter type         axi_req_t  = axi_trace_capture_pkg::axi_req_t,
    parameter type         axi_resp_t = axi_trace_capture_pkg::axi_resp_t,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned Depth      = 16,
    parameter int unsigned TsWidth    = 32,
    parameter int unsigned WaitWidth  = 8,
    parameter int unsigned DropWidth  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  axi_req_t                   axi_req_i,
    input  axi_resp_t                  axi_resp_i,
    output logic                       rec_valid_o,
    input  logic                       rec_ready_i,
    output logic                       rec_is_read_o,
    output logic [IdWidth-1:0]         rec_id_o,
    output logic [AddrWidth-1:0]       rec_addr_o,
    output logic [7:0]                 rec_len_o,
    output logic [TsWidth-1:0]         rec_ts_o,
    output logic [WaitWidth-1:0]       rec_wait_o,
    output logic [$clog2(Depth+1)-1:0] fill_o,
    output logic [DropWidth-1:0]       drop_cnt_o,
    input  logic                       clear_drops_i
);

    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned FillW = $clog2(Depth+1);

    typedef struct packed {
        logic                 is_read;
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [TsWidth-1:0]   ts;
        logic [WaitWidth-1:0] wait_cnt;
    } rec_t;

    rec_t                 r_mem [Depth];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [FillW-1:0]     r_fill;
    logic [DropWidth-1:0] r_drop;
    logic [TsWidth-1:0]   r_ts;
    logic [WaitWidth-1:0] r_aw_wait;
    logic [WaitWidth-1:0] r_ar_wait;

    logic                 w_aw_hs;
    logic                 w_ar_hs;
    logic                 w_aw_req;
    logic                 w_ar_req;
    logic                 w_aw_acc;
    logic                 w_ar_acc;
    logic [FillW-1:0]     w_free;
    logic [1:0]           w_n_drop;
    logic [DropWidth:0]   w_drop_sum;
    logic                 w_pop;
    logic [PtrW-1:0]      w_ar_idx;
    rec_t                 w_aw_rec;
    rec_t                 w_ar_rec;
    rec_t                 w_head;

    assign w_aw_hs  = axi_req_i.aw_valid && axi_resp_i.aw_ready;
    assign w_ar_hs  = axi_req_i.ar_valid && axi_resp_i.ar_ready;
    assign w_aw_req = enable_i && w_aw_hs;
    assign w_ar_req = enable_i && w_ar_hs;

    // Space is judged on occupancy before this cycle's pop; AW always claims the first slot.
    assign w_free   = FillW'(Depth) - r_fill;
    assign w_aw_acc = w_aw_req && (w_free != '0);
    assign w_ar_acc = w_ar_req && (w_aw_acc ? (w_free >= FillW'(2)) : (w_free != '0));
    assign w_n_drop = {1'b0, w_aw_req && !w_aw_acc} + {1'b0, w_ar_req && !w_ar_acc};
    assign w_drop_sum = {1'b0, r_drop} + (DropWidth+1)'(w_n_drop);

    assign w_pop    = (r_fill != '0) && rec_ready_i;
    assign w_ar_idx = w_aw_acc ? (r_wptr + PtrW'(1)) : r_wptr;

    assign w_aw_rec = {1'b0, axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len, r_ts, r_aw_wait};
    assign w_ar_rec = {1'b1, axi_req_i.ar.id, axi_req_i.ar.addr, axi_req_i.ar.len, r_ts, r_ar_wait};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fill    <= '0;
            r_drop    <= '0;
            r_ts      <= '0;
            r_aw_wait <= '0;
            r_ar_wait <= '0;
        end else begin
            r_ts   <= r_ts + TsWidth'(1);
            r_wptr <= r_wptr + PtrW'(w_aw_acc) + PtrW'(w_ar_acc);
            r_rptr <= r_rptr + PtrW'(w_pop);
            r_fill <= r_fill + FillW'(w_aw_acc) + FillW'(w_ar_acc) - FillW'(w_pop);

            if (clear_drops_i)
                r_drop <= '0;
            else if (w_drop_sum[DropWidth])
                r_drop <= '1;
            else
                r_drop <= w_drop_sum[DropWidth-1:0];

            if (w_aw_hs)
                r_aw_wait <= '0;
            else if (axi_req_i.aw_valid && (r_aw_wait != '1))
                r_aw_wait <= r_aw_wait + WaitWidth'(1);

            if (w_ar_hs)
                r_ar_wait <= '0;
            else if (axi_req_i.ar_valid && (r_ar_wait != '1))
                r_ar_wait <= r_ar_wait + WaitWidth'(1);
        end
    end

    // NOTE: the storage array has no reset; entries are only observable once fill says they were written.
    always_ff @(posedge clk_i) begin
        if (w_aw_acc)
            r_mem[r_wptr] <= w_aw_rec;
        if (w_ar_acc)
            r_mem[w_ar_idx] <= w_ar_rec;
    end

    assign w_head        = r_mem[r_rptr];
    assign rec_valid_o   = (r_fill != '0);
    assign rec_is_read_o = w_head.is_read;
    assign rec_id_o      = w_head.id;
    assign rec_addr_o    = w_head.addr;
    assign rec_len_o     = w_head.len;
    assign rec_ts_o      = w_head.ts;
    assign rec_wait_o    = w_head.wait_cnt;
    assign fill_o        = r_fill;
    assign drop_cnt_o    = r_drop;

endmodule

// File: tb/tb_axi_trace_capture.sv
// Directed bench for axi_trace_capture: expected records go into a queue,
// a negedge monitor pops and compares each record the DUT hands over.

module tb_axi_trace_capture;
    import axi_trace_capture_pkg::*;

    typedef struct {
        logic        is_read;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] ts;
        logic [7:0]  wt;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    axi_req_t    axi_req_i;
    axi_resp_t   axi_resp_i;
    logic        rec_valid_o;
    logic        rec_ready_i;
    logic        rec_is_read_o;
    logic [3:0]  rec_id_o;
    logic [31:0] rec_addr_o;
    logic [7:0]  rec_len_o;
    logic [31:0] rec_ts_o;
    logic [7:0]  rec_wait_o;
    logic [4:0]  fill_o;
    logic [15:0] drop_cnt_o;
    logic        clear_drops_i;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    axi_trace_capture dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .axi_req_i     (axi_req_i),
        .axi_resp_i    (axi_resp_i),
        .rec_valid_o   (rec_valid_o),
        .rec_ready_i   (rec_ready_i),
        .rec_is_read_o (rec_is_read_o),
        .rec_id_o      (rec_id_o),
        .rec_addr_o    (rec_addr_o),
        .rec_len_o     (rec_len_o),
        .rec_ts_o      (rec_ts_o),
        .rec_wait_o    (rec_wait_o),
        .fill_o        (fill_o),
        .drop_cnt_o    (drop_cnt_o),
        .clear_drops_i (clear_drops_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_exp(input logic is_read, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [31:0] ts, input logic [7:0] wt);
        exp_t e;
        e.is_read = is_read;
        e.id      = id;
        e.addr    = addr;
        e.len     = len;
        e.ts      = ts;
        e.wt      = wt;
        exp_q.push_back(e);
    endtask

    task automatic drive_aw(input logic v, input logic r, input logic [3:0] id,
                            input logic [31:0] addr, input logic [7:0] len);
        axi_req_i.aw_valid  = v;
        axi_resp_i.aw_ready = r;
        axi_req_i.aw.id     = id;
        axi_req_i.aw.addr   = addr;
        axi_req_i.aw.len    = len;
    endtask

    task automatic drive_ar(input logic v, input logic r, input logic [3:0] id,
                            input logic [31:0] addr, input logic [7:0] len);
        axi_req_i.ar_valid  = v;
        axi_resp_i.ar_ready = r;
        axi_req_i.ar.id     = id;
        axi_req_i.ar.addr   = addr;
        axi_req_i.ar.len    = len;
    endtask

    // Scoreboard monitor: a record is consumed whenever valid and ready are both high at the edge.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && rec_valid_o === 1'b1 && rec_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", 64'(rec_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rec_is_read", 64'(rec_is_read_o), 64'(e.is_read));
                check("rec_id",      64'(rec_id_o),      64'(e.id));
                check("rec_addr",    64'(rec_addr_o),    64'(e.addr));
                check("rec_len",     64'(rec_len_o),     64'(e.len));
                check("rec_ts",      64'(rec_ts_o),      64'(e.ts));
                check("rec_wait",    64'(rec_wait_o),    64'(e.wt));
            end
        end
    end

    initial begin
        rst_ni        = 1'b0;
        enable_i      = 1'b0;
        rec_ready_i   = 1'b0;
        clear_drops_i = 1'b0;
        axi_req_i     = '0;
        axi_resp_i    = '0;
        tick();
        tick();
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        rec_ready_i = 1'b1;
        cyc      = 0;

        check("reset_valid", 64'(rec_valid_o), 64'd0);
        check("reset_fill",  64'(fill_o),      64'd0);
        check("reset_drops", 64'(drop_cnt_o),  64'd0);

        // AW valid from cycle 5, ready at cycle 8: wait 3, ts 8, visible at cycle 9.
        go_to(5);
        drive_aw(1'b1, 1'b0, 4'd3, 32'h0000_1000, 8'd7);
        go_to(8);
        axi_resp_i.aw_ready = 1'b1;
        push_exp(1'b0, 4'd3, 32'h0000_1000, 8'd7, 32'd8, 8'd3);
        check("valid_before_write", 64'(rec_valid_o), 64'd0);
        tick();
        drive_aw(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        check("valid_at_cycle9", 64'(rec_valid_o), 64'd1);
        check("fill_at_cycle9",  64'(fill_o),      64'd1);

        // Same-cycle AW and AR handshake into an empty FIFO at ts 20.
        go_to(19);
        rec_ready_i = 1'b0;
        go_to(20);
        drive_aw(1'b1, 1'b1, 4'd1, 32'h0000_2000, 8'd0);
        drive_ar(1'b1, 1'b1, 4'd2, 32'h0000_3000, 8'd3);
        push_exp(1'b0, 4'd1, 32'h0000_2000, 8'd0, 32'd20, 8'd0);
        push_exp(1'b1, 4'd2, 32'h0000_3000, 8'd3, 32'd20, 8'd0);
        tick();
        drive_aw(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        drive_ar(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        check("dual_fill", 64'(fill_o), 64'd2);
        rec_ready_i = 1'b1;
        go_to(23);
        check("dual_drained", 64'(fill_o), 64'd0);

        // 17 back-to-back AW handshakes with the consumer stalled: 16 stored, 1 dropped.
        go_to(29);
        rec_ready_i = 1'b0;
        for (int k = 0; k < 17; k++) begin
            go_to(30 + k);
            drive_aw(1'b1, 1'b1, 4'(k), 32'h100 * k, 8'(k));
            if (k < 16)
                push_exp(1'b0, 4'(k), 32'h100 * k, 8'(k), 32'(30 + k), 8'd0);
        end
        go_to(47);
        check("full_fill",  64'(fill_o),     64'd16);
        check("full_drops", 64'(drop_cnt_o), 64'd1);
        // Handshake with capture disabled while full: nothing stored, nothing counted.
        enable_i = 1'b0;
        drive_aw(1'b1, 1'b1, 4'hF, 32'hFFFF_0000, 8'd1);
        tick();
        enable_i = 1'b1;
        drive_aw(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        check("disabled_fill",  64'(fill_o),     64'd16);
        check("disabled_drops", 64'(drop_cnt_o), 64'd1);
        clear_drops_i = 1'b1;
        rec_ready_i   = 1'b1;
        tick();
        clear_drops_i = 1'b0;
        check("cleared_drops", 64'(drop_cnt_o), 64'd0);
        check("fill_after_pop", 64'(fill_o),    64'd15);

        // fill 15, dual handshake plus pop: AW stored, AR dropped, fill stays 15.
        drive_aw(1'b1, 1'b1, 4'hA, 32'hAAAA_0000, 8'd9);
        drive_ar(1'b1, 1'b1, 4'hB, 32'hBBBB_0000, 8'd4);
        push_exp(1'b0, 4'hA, 32'hAAAA_0000, 8'd9, 32'd49, 8'd0);
        tick();
        drive_aw(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        drive_ar(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        check("partial_fill",  64'(fill_o),     64'd15);
        check("partial_drops", 64'(drop_cnt_o), 64'd1);
        go_to(70);
        check("drained_fill", 64'(fill_o), 64'd0);

        // AR valid for 300 cycles before ready: wait saturates at 255.
        go_to(80);
        drive_ar(1'b1, 1'b0, 4'd5, 32'hDEAD_BEE0, 8'd1);
        go_to(380);
        axi_resp_i.ar_ready = 1'b1;
        push_exp(1'b1, 4'd5, 32'hDEAD_BEE0, 8'd1, 32'd380, 8'd255);
        tick();
        drive_ar(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        go_to(385);
        check("sat_drained", 64'(fill_o), 64'd0);

        // Five records buffered, then synchronous reset discards them.
        go_to(399);
        rec_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            go_to(400 + k);
            drive_aw(1'b1, 1'b1, 4'(k + 8), 32'h5000 + 32'(k), 8'd0);
        end
        go_to(405);
        drive_aw(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        check("prereset_fill", 64'(fill_o), 64'd5);
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        tick();
        check("midreset_valid", 64'(rec_valid_o), 64'd0);
        check("midreset_fill",  64'(fill_o),      64'd0);
        check("midreset_drops", 64'(drop_cnt_o),  64'd0);
        rst_ni      = 1'b1;
        enable_i    = 1'b1;
        rec_ready_i = 1'b1;
        cyc         = 0;

        // Timestamp restarts from zero after reset.
        go_to(3);
        drive_aw(1'b1, 1'b1, 4'd6, 32'h0000_0600, 8'd2);
        push_exp(1'b0, 4'd6, 32'h0000_0600, 8'd2, 32'd3, 8'd0);
        tick();
        drive_aw(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
        go_to(10);
        check("final_fill", 64'(fill_o), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
